single_port_sync_ram_ia: RTL and testbench

- Single-port synchronous SRAM model with a bidirectional data bus and chip-select, write-enable and output-enable controls.
- The effective address is base-plus-offset: addr + indirect_addr. This supports indexed (pointer-relative) access from the processor datapath.
- Serves as the data/instruction memory of the course CPU. The CPU or testbench drives the shared data bus while oe=0, and the RAM drives it while reading.

---
 rtl/single_port_sync_ram_ia_if.sv | 32 +++
 rtl/single_port_sync_ram_ia.sv | 78 +++++++
 tb/tb_single_port_sync_ram_ia.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/single_port_sync_ram_ia_if.sv
// Control/address bundle for single_port_sync_ram_ia. The parity_err signal
// is present only when RAM_PARITY_EN is defined.
interface single_port_sync_ram_ia_if #(
    parameter int ADDR_WIDTH = 13
) ();
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] indirect_addr;
    logic                  cs;
    logic                  we;
    logic                  oe;
`ifdef RAM_PARITY_EN
    logic                  parity_err;

    modport master (
        output addr, indirect_addr, cs, we, oe,
        input  parity_err
    );

    modport slave (
        input  addr, indirect_addr, cs, we, oe,
        output parity_err
    );
`else
    modport master (
        output addr, indirect_addr, cs, we, oe
    );

    modport slave (
        input  addr, indirect_addr, cs, we, oe
    );
`endif
endinterface

// File: rtl/single_port_sync_ram_ia.sv
// Single-port synchronous RAM addressed by addr + indirect_addr (wrapping),
// tristate data bus. Define RAM_PARITY_EN to add per-word even parity checking.
module single_port_sync_ram_ia #(
    parameter  int ADDR_WIDTH = 13,
    parameter  int DATA_WIDTH = 8,
    localparam int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    single_port_sync_ram_ia_if.slave bus,
    // data stays a plain inout so the shared-bus drivers resolve at module level
    inout  wire  [DATA_WIDTH-1:0]  data
);

`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] w);
        return ^w;
    endfunction

    logic [MEM_W-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] ea;
    logic [MEM_W-1:0]      word_in;
    logic [MEM_W-1:0]      word_rd;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rdata_p1;

    // Carry out of the base+offset sum is dropped, giving wrap-around addressing.
    assign ea      = bus.addr + bus.indirect_addr;
    assign wr_en   = bus.cs &&  bus.we;
    assign rd_en   = bus.cs && !bus.we;
    assign word_rd = mem[ea];

`ifdef RAM_PARITY_EN
    assign word_in = {even_parity(data), data};
`else
    assign word_in = data;
`endif

    // Stage p0 -> array: an edge seen while rst is high performs no write.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[ea] <= word_in;
        end
    end

    // Stage p0 -> p1: registered read word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_p1 <= '0;
        end else if (rd_en) begin
            rdata_p1 <= word_rd[DATA_WIDTH-1:0];
        end
    end

`ifdef RAM_PARITY_EN
    logic parity_err_p1;

    // Stored bit plus data must XOR to zero; any other result is a mismatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_p1 <= 1'b0;
        end else begin
            parity_err_p1 <= rd_en && (word_rd[DATA_WIDTH] != even_parity(word_rd[DATA_WIDTH-1:0]));
        end
    end

    assign bus.parity_err = parity_err_p1;
`endif

    assign data = (!rst && rd_en && bus.oe) ? rdata_p1 : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_single_port_sync_ram_ia.sv
// Directed bench for single_port_sync_ram_ia: write/read-back, bus release,
// indexed and wrapped addressing, deselect and asynchronous reset.
module tb_single_port_sync_ram_ia;
    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tb_drv = 1'b0;
    logic [DW-1:0] tb_data = '0;
    wire  [DW-1:0] data;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] tbl [16] = '{
        8'h3A, 8'hC5, 8'h7E, 8'h92, 8'h4D, 8'hB1, 8'h06, 8'hE8,
        8'h59, 8'h2F, 8'hD3, 8'h81, 8'h6C, 8'h17, 8'hF4, 8'hA0
    };

    single_port_sync_ram_ia_if #(.ADDR_WIDTH(AW)) ram_if ();

    single_port_sync_ram_ia #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (ram_if.slave),
        .data (data)
    );

    assign data = tb_drv ? tb_data : {DW{1'bz}};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ctl(input logic c, input logic w, input logic o,
                           input logic [AW-1:0] a, input logic [AW-1:0] ia);
        ram_if.cs            = c;
        ram_if.we            = w;
        ram_if.oe            = o;
        ram_if.addr          = a;
        ram_if.indirect_addr = ia;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_ctl(1'b0, 1'b0, 1'b0, '0, '0);
        #1 rst = 1'b1;
        #12 rst = 1'b0;

        // Reset state: read path selected, no edge yet, register shows cleared value.
        set_ctl(1'b1, 1'b0, 1'b1, '0, '0);
        #1 chk("reset_rdata", data, 8'h00);

        // Write 16 bytes, then read them back with one cycle of latency.
        tb_drv = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_ctl(1'b1, 1'b1, 1'b0, AW'(i), '0);
            tb_data = tbl[i];
            tick();
        end
        tb_drv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_ctl(1'b1, 1'b0, 1'b1, AW'(i), '0);
            tick();
            chk($sformatf("readback_%0d", i), data, tbl[i]);
        end

        // Bus release: oe=0 read while the bench drives the bus.
        set_ctl(1'b1, 1'b0, 1'b0, 13'd3, '0);
        tb_drv  = 1'b1;
        tb_data = 8'h05;
        tick();
        chk("release_no_contention", data, 8'h05);
        tb_drv = 1'b0;
        set_ctl(1'b1, 1'b0, 1'b1, 13'd3, '0);
        tick();
        chk("release_mem_intact", data, 8'h92);

        // Indexed addressing: 100 + 5 -> 105.
        set_ctl(1'b1, 1'b1, 1'b0, 13'd100, 13'd5);
        tb_drv  = 1'b1;
        tb_data = 8'hA5;
        tick();
        tb_drv = 1'b0;
        set_ctl(1'b1, 1'b0, 1'b1, 13'd105, 13'd0);
        tick();
        chk("indexed_read", data, 8'hA5);
        set_ctl(1'b1, 1'b0, 1'b1, 13'd0, 13'd105);
        tick();
        chk("indexed_read_offset_only", data, 8'hA5);

        // Wrap-around: 8190 + 4 -> 2.
        set_ctl(1'b1, 1'b1, 1'b0, 13'd8190, 13'd4);
        tb_drv  = 1'b1;
        tb_data = 8'h3C;
        tick();
        tb_drv = 1'b0;
        set_ctl(1'b1, 1'b0, 1'b1, 13'd2, 13'd0);
        tick();
        chk("wrap_read", data, 8'h3C);

        // Deselect: no write, bus stays undriven with oe=1.
        set_ctl(1'b0, 1'b1, 1'b0, 13'd0, '0);
        tb_drv  = 1'b1;
        tb_data = 8'hFF;
        tick();
        set_ctl(1'b0, 1'b0, 1'b1, 13'd0, '0);
        tb_data = 8'h00;
        #1 chk("deselect_bus_released", data, 8'h00);
        tb_drv = 1'b0;
        set_ctl(1'b1, 1'b0, 1'b1, 13'd0, '0);
        tick();
        chk("deselect_no_write", data, 8'h3A);

        // Asynchronous reset mid-read.
        set_ctl(1'b1, 1'b0, 1'b1, 13'd3, '0);
        tick();
        chk("pre_reset_read", data, 8'h92);
        #2 rst = 1'b1;
        tb_drv  = 1'b1;
        tb_data = 8'h00;
        #1 chk("reset_bus_released", data, 8'h00);
        set_ctl(1'b1, 1'b1, 1'b0, 13'd3, '0);
        tb_data = 8'hEE;
        tick();
        tb_drv = 1'b0;
        set_ctl(1'b1, 1'b0, 1'b1, 13'd3, '0);
        rst = 1'b0;
        #1 chk("reset_cleared_rdata", data, 8'h00);
        tick();
        chk("post_reset_data_kept", data, 8'h92);
        set_ctl(1'b1, 1'b0, 1'b1, 13'd15, '0);
        tick();
        chk("post_reset_other_addr", data, 8'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
